// File: rtl/lm70_scan_ctrl.sv
// -----------------------------------------------------------------------------
// lm70_scan_ctrl
//
// Round-robin SPI scan controller for up to four LM70-class temperature
// sensors sharing one SCK/SIO pair, each with its own chip select. Every frame
// shifts FRAME_BITS bits in MSB first, converts the result to a signed integer
// degC value (arithmetic right shift by INT_SHIFT, truncated to 9 bits) and
// latches it into that channel's slot of temp_bus.
//
// Optional feature macro: LM70_ALARM_EN
//   defined   : per-channel over-temperature alarm with hysteresis
//               (set at temp >= thr_hi, clear at temp < thr_hi - HYST)
//   undefined : alarm is constant 0 and thr_hi is ignored
//
// Parameters
//   N_CH        number of sensor channels (1..4)
//   FRAME_BITS  SCK cycles per frame (9..16)
//   INT_SHIFT   arithmetic right shift giving integer degC
//   CLK_DIV     SCK half-period in clk cycles (1..15)
//   IDLE_CYCLES cs_n-high gap between frames (>= 1)
//   HYST        alarm hysteresis in degC (0..15)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   ch_en     channel enable mask, sampled when a frame is about to start
//   thr_hi    signed alarm threshold, degC
//   sio       shared serial data from the sensors
//   cs_n      active-low chip selects, at most one low
//   sck       SPI clock, idle low
//   rd_valid  one-cycle pulse announcing a new result on rd_ch / rd_temp
//   rd_ch     channel index of the current result
//   rd_temp   signed degC of the current result
//   temp_bus  latched per-channel temps, channel i at [9i+8:9i]
//   alarm     per-channel over-temperature flags
// -----------------------------------------------------------------------------
module lm70_scan_ctrl #(
  parameter int N_CH        = 2,
  parameter int FRAME_BITS  = 16,
  parameter int INT_SHIFT   = 7,
  parameter int CLK_DIV     = 1,
  parameter int IDLE_CYCLES = 4,
  parameter int HYST        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [8:0]        thr_hi,
  input  logic              sio,
  output logic [N_CH-1:0]   cs_n,
  output logic              sck,
  output logic              rd_valid,
  output logic [1:0]        rd_ch,
  output logic [8:0]        rd_temp,
  output logic [9*N_CH-1:0] temp_bus,
  output logic [N_CH-1:0]   alarm
);

  localparam int               GAP_W    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES - 1);
  localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_reg;
  logic [GAP_W-1:0]      gap_reg;
  logic [3:0]            div_reg;
  logic [4:0]            bit_reg;
  logic                  sck_reg;
  logic [N_CH-1:0]       cs_n_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [1:0]            cur_ch_reg;
  logic [1:0]            last_ch_reg;
  logic                  first_reg;
  logic                  rd_valid_reg;
  logic [1:0]            rd_ch_reg;
  logic [8:0]            rd_temp_reg;

  logic                  div_last;
  logic                  frame_end;
  logic [8:0]            temp_new;

  // ---------------------------------------------------------------------------
  // Next channel: first enabled index strictly after the last served one,
  // scanning circularly. Starting the scan from N_CH-1 while nothing has been
  // served yet makes the first frame land on the lowest enabled index. The
  // loop runs from the farthest candidate to the nearest so the nearest wins.
  // ---------------------------------------------------------------------------
  logic [3:0] en_pad;
  logic [1:0] base_ch;
  logic [2:0] cand;
  logic [1:0] next_ch;
  logic       any_en;

  always_comb begin
    en_pad  = 4'(ch_en);
    base_ch = first_reg ? 2'(N_CH - 1) : last_ch_reg;
    cand    = '0;
    next_ch = '0;
    any_en  = 1'b0;
    for (int off = N_CH; off >= 1; off--) begin
      cand = 3'(base_ch) + 3'(off);
      if (cand >= 3'(N_CH)) begin
        cand = cand - 3'(N_CH);
      end
      if (en_pad[cand[1:0]]) begin
        next_ch = cand[1:0];
        any_en  = 1'b1;
      end
    end
  end

  assign div_last  = (div_reg == DIV_LAST);
  assign frame_end = (state_reg == ST_DONE) && div_last;
  // Bit FRAME_BITS-1 is the sign; keep only the 9 integer bits after the shift.
  assign temp_new  = 9'($signed(shift_reg) >>> INT_SHIFT);

  // ---------------------------------------------------------------------------
  // Frame sequencer. The divider counts CLK_DIV cycles per SCK phase; DONE
  // holds cs_n low for one more half-period after the last falling SCK edge
  // before results are published and cs_n is released.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      gap_reg      <= '0;
      div_reg      <= '0;
      bit_reg      <= '0;
      sck_reg      <= 1'b0;
      cs_n_reg     <= '1;
      shift_reg    <= '0;
      cur_ch_reg   <= '0;
      last_ch_reg  <= '0;
      first_reg    <= 1'b1;
      rd_valid_reg <= 1'b0;
      rd_ch_reg    <= '0;
      rd_temp_reg  <= '0;
    end else begin
      rd_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (gap_reg == GAP_LAST) begin
            gap_reg <= '0;
            if (any_en) begin
              cs_n_reg   <= ~(N_CH'(1) << next_ch);
              cur_ch_reg <= next_ch;
              div_reg    <= '0;
              bit_reg    <= '0;
              state_reg  <= ST_SHIFT;
            end
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (div_last) begin
            div_reg <= '0;
            if (!sck_reg) begin
              sck_reg   <= 1'b1;
              shift_reg <= {shift_reg[FRAME_BITS-2:0], sio};
            end else begin
              sck_reg <= 1'b0;
              if (bit_reg == BIT_LAST) begin
                state_reg <= ST_DONE;
              end else begin
                bit_reg <= bit_reg + 1'b1;
              end
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end

        ST_DONE: begin
          if (div_last) begin
            div_reg      <= '0;
            cs_n_reg     <= '1;
            rd_valid_reg <= 1'b1;
            rd_ch_reg    <= cur_ch_reg;
            rd_temp_reg  <= temp_new;
            last_ch_reg  <= cur_ch_reg;
            first_reg    <= 1'b0;
            gap_reg      <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cs_n     = cs_n_reg;
  assign sck      = sck_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_ch    = rd_ch_reg;
  assign rd_temp  = rd_temp_reg;

  // Per-channel result slots; a channel that stops being served keeps its value.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
    logic [8:0] slot_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (frame_end && (cur_ch_reg == 2'(gi))) begin
        slot_reg <= temp_new;
      end
    end
    assign temp_bus[9*gi +: 9] = slot_reg;
  end

`ifdef LM70_ALARM_EN
  // Compare in 10 bits so thr_hi - HYST cannot wrap near -256.
  logic signed [9:0] temp_ext;
  logic signed [9:0] thr_ext;
  logic signed [9:0] thr_lo;

  assign temp_ext = {temp_new[8], temp_new};
  assign thr_ext  = {thr_hi[8], thr_hi};
  assign thr_lo   = thr_ext - 10'(HYST);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_alarm
    logic alarm_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alarm_reg <= 1'b0;
      end else if (frame_end && (cur_ch_reg == 2'(gi))) begin
        if (temp_ext >= thr_ext) begin
          alarm_reg <= 1'b1;
        end else if (temp_ext < thr_lo) begin
          alarm_reg <= 1'b0;
        end
      end
    end
    assign alarm[gi] = alarm_reg;
  end
`else
  logic unused_thr;
  assign unused_thr = ^thr_hi;
  assign alarm      = '0;
`endif

endmodule
